// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and helpers for the VGA pixel pipeline
package vga_pkg;

  localparam int RGB_W = 12;
  localparam int HC_W  = 11;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic {
    LAYER_OPAQUE = 1'b0,
    LAYER_BLEND  = 1'b1
  } layer_mode_e;

  typedef struct packed {
    logic [HC_W-1:0] hcount;
    logic [HC_W-1:0] vcount;
    logic            hsync;
    logic            vsync;
    logic            hblnk;
    logic            vblnk;
  } vga_timing_t;

  // Per-channel 50% mix; the 5-bit sum is truncated, so 15 + 0 gives 7.
  function automatic rgb_t rgb_avg(rgb_t a, rgb_t b);
    rgb_t       r;
    logic [4:0] s;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      s = {1'b0, a[4*c +: 4]} + {1'b0, b[4*c +: 4]};
      r[4*c +: 4] = s[4:1];
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA pixel stream bundle (timing fields plus colour)
interface vga_if;
  import vga_pkg::*;

  logic [HC_W-1:0] hcount;
  logic [HC_W-1:0] vcount;
  logic            hsync;
  logic            vsync;
  logic            hblnk;
  logic            vblnk;
  rgb_t            rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_if_delay.sv
// rtl/vga_if_delay.sv - registered DEPTH-stage delay of the vga timing fields
module vga_if_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  vga_timing_t din,
  output vga_timing_t dout
);

  vga_timing_t pipe [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/vga_layer_mux.sv
// rtl/vga_layer_mux.sv - overlay compositor with colour key, blend, frame-synced config
// and per-frame collision statistics; 2-cycle latency on every stream field.
module vga_layer_mux
  import vga_pkg::*;
#(
  parameter int   NUM_LAYERS = 4,
  parameter rgb_t KEY_RGB    = 12'hF0F,
  parameter int   CNT_W      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  vga_if.in                                in_if,
  input  logic [NUM_LAYERS-1:0]            layer_hit,
  input  logic [NUM_LAYERS-1:0][RGB_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]            cfg_en,
  input  logic [NUM_LAYERS-1:0]            cfg_blend,
  vga_if.out                               out_if,
  output logic [CNT_W-1:0]                 frame_cnt,
  output logic                             coll_flag,
  output logic [CNT_W-1:0]                 coll_pixels
);

  logic                            vsync_q;
  logic                            vsync_rise;
  logic [NUM_LAYERS-1:0]           act_en;
  logic [NUM_LAYERS-1:0]           act_blend;
  logic [NUM_LAYERS-1:0]           vis_now;
  logic                            coll_hit;
  logic [CNT_W-1:0]                coll_run;

  rgb_t                            s1_bg;
  logic [NUM_LAYERS-1:0][RGB_W-1:0] s1_rgb;
  logic [NUM_LAYERS-1:0]           s1_vis;
  logic [NUM_LAYERS-1:0]           s1_blend;
  logic                            s1_blank;
  rgb_t                            acc;
  rgb_t                            rgb_q;

  vga_timing_t                     tim_in;
  vga_timing_t                     tim_out;

  assign vsync_rise = in_if.vsync & ~vsync_q;

  always_comb begin
    vis_now = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      vis_now[i] = layer_hit[i] & act_en[i] & (layer_rgb[i] != KEY_RGB);
  end

  // A collision is two or more visible layers on one non-blanked pixel.
  if (NUM_LAYERS > 1) begin : g_coll
    logic seen;
    logic multi;
    always_comb begin
      seen  = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (vis_now[i]) begin
          multi = multi | seen;
          seen  = 1'b1;
        end
      end
    end
    assign coll_hit = multi & ~(in_if.hblnk | in_if.vblnk);
  end else begin : g_no_coll
    assign coll_hit = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q     <= 1'b0;
      act_en      <= '0;
      act_blend   <= '0;
      frame_cnt   <= '0;
      coll_run    <= '0;
      coll_pixels <= '0;
      coll_flag   <= 1'b0;
    end else begin
      vsync_q <= in_if.vsync;
      if (vsync_rise) begin
        act_en      <= cfg_en;
        act_blend   <= cfg_blend;
        frame_cnt   <= frame_cnt + CNT_W'(1);
        coll_pixels <= coll_run;
        coll_flag   <= |coll_run;
        coll_run    <= coll_hit ? CNT_W'(1) : '0;
      end else if (coll_hit && (coll_run != '1)) begin
        coll_run <= coll_run + CNT_W'(1);
      end
    end
  end

  // Blend modes are captured with the pixel so a config swap cannot split one pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_bg    <= '0;
      s1_rgb   <= '0;
      s1_vis   <= '0;
      s1_blend <= '0;
      s1_blank <= 1'b0;
      rgb_q    <= '0;
    end else begin
      s1_bg    <= in_if.rgb;
      s1_rgb   <= layer_rgb;
      s1_vis   <= vis_now;
      s1_blend <= act_blend;
      s1_blank <= in_if.hblnk | in_if.vblnk;
      rgb_q    <= s1_blank ? '0 : acc;
    end
  end

  always_comb begin
    acc = s1_bg;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (s1_vis[i])
        acc = (layer_mode_e'(s1_blend[i]) == LAYER_BLEND) ? rgb_avg(acc, s1_rgb[i]) : s1_rgb[i];
    end
  end

  assign tim_in = '{hcount: in_if.hcount, vcount: in_if.vcount, hsync: in_if.hsync,
                    vsync: in_if.vsync, hblnk: in_if.hblnk, vblnk: in_if.vblnk};

  vga_if_delay #(.DEPTH(2)) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (tim_in),
    .dout (tim_out)
  );

  assign out_if.hcount = tim_out.hcount;
  assign out_if.vcount = tim_out.vcount;
  assign out_if.hsync  = tim_out.hsync;
  assign out_if.vsync  = tim_out.vsync;
  assign out_if.hblnk  = tim_out.hblnk;
  assign out_if.vblnk  = tim_out.vblnk;
  assign out_if.rgb    = rgb_q;

endmodule
